// File: rtl/fp_less_equal_pkg.sv
// Shared binary32 field layout, result constants and operand classes for the
// floating-point less-or-equal comparator.
package fp_less_equal_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int WORD_W = SIGN_W + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0]  EXP_ONES     = 8'hFF;
  localparam logic [WORD_W-1:0] RESULT_TRUE  = 32'h0000_0001;
  localparam logic [WORD_W-1:0] RESULT_FALSE = 32'h0000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBNORMAL,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Decodes one binary32 word into its operand class and sign bit.
module fp_classify
  import fp_less_equal_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output fp_class_e         class_o,
  output logic              sign_o
);

  logic [EXP_W-1:0]  exp_w;
  logic [MANT_W-1:0] mant_w;

  assign sign_o = word_i[WORD_W-1];
  assign exp_w  = word_i[WORD_W-SIGN_W-1 -: EXP_W];
  assign mant_w = word_i[MANT_W-1:0];

  always_comb begin
    class_o = CLS_NORMAL;
    if (exp_w == EXP_ONES) begin
      class_o = (mant_w != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_w == '0) begin
      class_o = (mant_w != '0) ? CLS_SUBNORMAL : CLS_ZERO;
    end
  end

endmodule

// File: rtl/fp_less_equal.sv
// Pipelined IEEE-754 binary32 "value1 <= value2" comparator: stage 1 holds the
// decided flag, remaining stages delay it so the result lands LATENCY cycles later.
module fp_less_equal
  import fp_less_equal_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [WORD_W-1:0] value1,
  input  logic [WORD_W-1:0] value2,
  output logic [WORD_W-1:0] result
);

  fp_class_e               cls1, cls2;
  logic                    sgn1, sgn2;
  logic [WORD_W-SIGN_W-1:0] mag1, mag2;
  logic                    flag_d;
  logic [LATENCY-1:0]      flag_q;

  fp_classify u_cls1 (
    .word_i  (value1),
    .class_o (cls1),
    .sign_o  (sgn1)
  );

  fp_classify u_cls2 (
    .word_i  (value2),
    .class_o (cls2),
    .sign_o  (sgn2)
  );

  assign mag1 = value1[WORD_W-SIGN_W-1:0];
  assign mag2 = value2[WORD_W-SIGN_W-1:0];

  // Sign-magnitude encoding orders as an unsigned integer within one sign,
  // so infinities and subnormals need no special casing beyond NaN and zero.
  always_comb begin
    flag_d = 1'b0;
    if (cls1 == CLS_NAN || cls2 == CLS_NAN) begin
      flag_d = 1'b0;
    end else if (cls1 == CLS_ZERO && cls2 == CLS_ZERO) begin
      flag_d = 1'b1;
    end else if (sgn1 != sgn2) begin
      flag_d = sgn1;
    end else if (!sgn1) begin
      flag_d = (mag1 <= mag2);
    end else begin
      flag_d = (mag1 >= mag2);
    end
  end

  // Stage 1 captures the flag; stages 2..LATENCY form a plain delay line.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      flag_q <= '0;
    end else begin
      flag_q[0] <= flag_d;
      for (int i = 1; i < LATENCY; i++) begin
        flag_q[i] <= flag_q[i-1];
      end
    end
  end

  assign result = flag_q[LATENCY-1] ? RESULT_TRUE : RESULT_FALSE;

endmodule

// File: tb/tb_fp_less_equal.sv
// Randomized bench for fp_less_equal against a real-number reference model.
module tb_fp_less_equal;

  localparam int LAT  = 2;
  localparam int HMAX = 4096;

  logic        aclk;
  logic        areset;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [31:0] result;

  int    n_tests;
  int    n_fail;
  int    edge_cnt;
  int    last_rst;
  bit    flag_hist [0:HMAX-1];
  string tag_hist  [0:HMAX-1];

  logic [31:0] specials [0:11];

  fp_less_equal #(.LATENCY(LAT)) dut (
    .aclk   (aclk),
    .areset (areset),
    .value1 (value1),
    .value2 (value2),
    .result (result)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // Numeric value of a non-NaN binary32; infinity maps beyond any finite float.
  function automatic real to_real(input logic [31:0] w);
    int  e;
    real m;
    real r;
    e = int'(w[30:23]);
    m = real'(w[22:0]);
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * (2.0 ** (-149.0));
    else             r = (m + 8388608.0) * (2.0 ** real'(e - 150));
    return w[31] ? -r : r;
  endfunction

  function automatic bit model_le(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return to_real(a) <= to_real(b);
  endfunction

  function automatic logic [31:0] gen_operand(input logic [31:0] other);
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: w = $urandom;
      1: w = specials[$urandom_range(0, 11)];
      2: w = other;
      3: w = other + 32'($urandom_range(0, 4)) - 32'd2;
      4: w = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
      default: w = {1'($urandom_range(0, 1)), 8'hFF, (($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'd0)};
    endcase
    if ($urandom_range(0, 3) == 0) w[31] = ~w[31];
    return w;
  endfunction

  // Apply one operand pair for one rising edge, then check the output after it.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input string tag);
    int          j;
    logic [31:0] exp;
    value1 = a;
    value2 = b;
    @(posedge aclk);
    edge_cnt++;
    flag_hist[edge_cnt] = model_le(a, b);
    tag_hist[edge_cnt]  = tag;
    #1;
    j = edge_cnt - LAT + 1;
    if (areset || j <= last_rst) begin
      chk("post_rst_zero", result, 32'd0);
    end else begin
      exp = flag_hist[j] ? 32'd1 : 32'd0;
      chk(tag_hist[j], result, exp);
    end
    @(negedge aclk);
  endtask

  task automatic rand_steps(input int n);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < n; i++) begin
      a = gen_operand($urandom);
      b = gen_operand(a);
      if ($urandom_range(0, 1) == 1) step(a, b, "rand");
      else                           step(b, a, "rand_sw");
    end
  endtask

  initial begin
    specials[0]  = 32'h0000_0000; specials[1]  = 32'h8000_0000;
    specials[2]  = 32'h7F80_0000; specials[3]  = 32'hFF80_0000;
    specials[4]  = 32'h7FC0_0000; specials[5]  = 32'h7F80_0001;
    specials[6]  = 32'h0000_0001; specials[7]  = 32'h807F_FFFF;
    specials[8]  = 32'h0080_0000; specials[9]  = 32'h7F7F_FFFF;
    specials[10] = 32'h3F80_0000; specials[11] = 32'hBF80_0000;

    n_tests  = 0;
    n_fail   = 0;
    edge_cnt = 0;
    last_rst = 0;
    areset   = 1'b1;
    value1   = 32'h3F80_0000;
    value2   = 32'h4000_0000;
    #2;
    chk("reset_state", result, 32'd0);
    @(negedge aclk);
    step(32'h3F80_0000, 32'h4000_0000, "in_reset");
    step(32'h3F80_0000, 32'h4000_0000, "in_reset");
    areset   = 1'b0;
    last_rst = edge_cnt;

    step(32'h3FC0_0000, 32'h4020_0000, "le_1p5_2p5");
    step(32'h3FC0_0000, 32'h3FC0_0000, "eq_1p5");
    step(32'h4020_0000, 32'h3FC0_0000, "gt_2p5_1p5");
    step(32'h8000_0000, 32'h0000_0000, "negz_posz");
    step(32'h0000_0000, 32'h8000_0000, "posz_negz");
    step(32'hC000_0000, 32'hBF80_0000, "neg2_neg1");
    step(32'hBF80_0000, 32'hC000_0000, "neg1_neg2");
    step(32'h7FC0_0000, 32'h3F80_0000, "nan_one");
    step(32'h3F80_0000, 32'h7F80_0001, "one_snan");
    step(32'h7FC0_0000, 32'h7FC0_0000, "nan_nan");
    step(32'h3F80_0000, 32'h7F80_0000, "one_pinf");
    step(32'hFF80_0000, 32'hFF7F_FFFF, "ninf_nmax");
    step(32'h7F80_0000, 32'h7F80_0000, "pinf_pinf");
    step(32'h0000_0001, 32'h0000_0002, "sub_1_2");
    step(32'h0000_0002, 32'h0000_0001, "sub_2_1");
    step(32'h8000_0001, 32'h0000_0000, "nsub_posz");
    step(32'h0000_0001, 32'h8000_0000, "psub_negz");
    step(32'h3F80_0000, 32'hBF80_0000, "pos_neg");
    rand_steps(400);

    // Mid-stream reset with operands changing every cycle.
    #2;
    areset = 1'b1;
    #1;
    chk("rst_async_clear", result, 32'd0);
    @(negedge aclk);
    step(32'h3F80_0000, 32'h4000_0000, "in_reset");
    step(32'h0000_0000, 32'h8000_0000, "in_reset");
    areset   = 1'b0;
    last_rst = edge_cnt;
    rand_steps(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
